one_two_checker: RTL

//  Response-side companion to the one/two-set detector. The stimulus side drives input vectors.

---
 rtl/one_two_pkg.sv | 15 +
 rtl/one_two_checker_if.sv | 28 ++
 rtl/one_two_ref.sv | 16 +
 rtl/one_two_checker.sv | 90 +++++++++
 4 files changed

// File: rtl/one_two_pkg.sv
// one_two_pkg: shared FSM state encoding and popcount helper for the one/two checker.
package one_two_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic int unsigned popcount(input logic [31:0] v);
      popcount = 0;
      for (int i = 0; i < 32; i++) popcount += 32'(v[i]);
   endfunction

endpackage

// File: rtl/one_two_checker_if.sv
// one_two_checker_if: sample stream from the stimulus side and the checker's report signals.
interface one_two_checker_if #(
   parameter int N_IN  = 3,
   parameter int ERR_W = 8
);
   logic                 start;
   logic                 in_valid;
   logic [N_IN-1:0]      in_bits;
   logic                 one;
   logic                 two;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [ERR_W-1:0]     err_count;
   logic [2**N_IN-1:0]   coverage;
   logic                 first_fail_vld;
   logic [N_IN-1:0]      first_fail_vec;

   modport master (
      output start, in_valid, in_bits, one, two,
      input  busy, done, pass, err_count, coverage, first_fail_vld, first_fail_vec
   );

   modport slave (
      input  start, in_valid, in_bits, one, two,
      output busy, done, pass, err_count, coverage, first_fail_vld, first_fail_vec
   );
endinterface

// File: rtl/one_two_ref.sv
// one_two_ref: combinational reference, flags vectors with exactly one or exactly two bits set.
module one_two_ref
   import one_two_pkg::*;
#(
   parameter int N_IN = 3
) (
   input  logic [N_IN-1:0] in_bits_i,
   output logic            exp_one_o,
   output logic            exp_two_o
);
   int unsigned pc;

   assign pc        = popcount(32'(in_bits_i));
   assign exp_one_o = pc == 1;
   assign exp_two_o = pc == 2;
endmodule

// File: rtl/one_two_checker.sv
// one_two_checker: checks DUT one/two responses, counts mismatches and tracks vector coverage.
// Optional ORDER_CHECK_EN also demands vectors arrive in ascending order.
module one_two_checker
   import one_two_pkg::*;
#(
   parameter int N_IN  = 3,
   parameter int ERR_W = 8
) (
   input logic               clock,
   input logic               reset,
   one_two_checker_if.slave  bus
);
   localparam int NV = 2**N_IN;

   state_e            state_q, state_d;
   logic [NV-1:0]     cov_q, cov_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic              ffv_q, ffv_d;
   logic [N_IN-1:0]   ffvec_q, ffvec_d;
   logic              exp_one, exp_two, ord_bad, hit, mism;

   one_two_ref #(.N_IN(N_IN)) u_ref (
      .in_bits_i (bus.in_bits),
      .exp_one_o (exp_one),
      .exp_two_o (exp_two)
   );

   // start wins over a same-cycle sample
   assign hit  = bus.in_valid && !bus.start && state_q == ARMED;
   assign mism = ({bus.one, bus.two} != {exp_one, exp_two}) || ord_bad;

`ifdef ORDER_CHECK_EN
   logic [N_IN-1:0] idx_q, idx_d;

   assign ord_bad = bus.in_bits != idx_q;
   assign idx_d   = bus.start ? '0 : (hit && !ord_bad) ? idx_q + 1'b1 : idx_q;

   always_ff @(posedge clock) begin
      if (reset) idx_q <= '0;
      else       idx_q <= idx_d;
   end
`else
   assign ord_bad = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cov_d   = cov_q;
      err_d   = err_q;
      ffv_d   = ffv_q;
      ffvec_d = ffvec_q;
      if (bus.start) begin
         state_d = ARMED;
         cov_d   = '0;
         err_d   = '0;
         ffv_d   = 1'b0;
         ffvec_d = '0;
      end else if (hit) begin
         cov_d   = cov_q | (NV'(1) << bus.in_bits);
         err_d   = (mism && !(&err_q)) ? err_q + 1'b1 : err_q;
         ffv_d   = ffv_q | mism;
         ffvec_d = (mism && !ffv_q) ? bus.in_bits : ffvec_q;
         state_d = &cov_d ? DONE : ARMED;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cov_q   <= '0;
         err_q   <= '0;
         ffv_q   <= 1'b0;
         ffvec_q <= '0;
      end else begin
         state_q <= state_d;
         cov_q   <= cov_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         ffvec_q <= ffvec_d;
      end
   end

   assign bus.busy           = state_q == ARMED;
   assign bus.done           = state_q == DONE;
   assign bus.pass           = state_q == DONE && err_q == '0;
   assign bus.err_count      = err_q;
   assign bus.coverage       = cov_q;
   assign bus.first_fail_vld = ffv_q;
   assign bus.first_fail_vec = ffvec_q;
endmodule
